diff_bcd_decoder: RTL and testbench
===================================

Name: diff_bcd_decoder

Overview:
Sequential reader for the (width+1)-bit signed result word produced by the team's n-bit subtractor. Bit [width] is the sign (1 = negative). Bits [width:0] together form the two's-complement difference. The block converts this word into sign + magnitude packed BCD for the calculator display path, using an iterative shift-add-3 (double-dabble) engine. Valid/ready handshakes are used on both sides.

Parameters:
width, 8, operand width of the subtractor; the input word is width+1 bits.
digits, 3, number of BCD output digits; must satisfy digits >= 1.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
rst_n_i  input  1  asynchronous active-low reset.
diff_i  input  width+1  signed difference word, two's complement; bit [width] is the sign.
valid_i  input  1  diff_i is valid.
ready_o  output  1  block can accept diff_i.
sign_o  output  1  1 = result negative.
bcd_o  output  4*digits  magnitude as packed BCD; digit 0 in bits [3:0].
ovf_o  output  1  magnitude exceeds 10^digits - 1; bcd_o holds the low digits only.
valid_o  output  1  sign_o, bcd_o and ovf_o are valid.
ready_i  input  1  downstream accepts the result.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state = IDLE, step counter = 0.
  - Working registers cleared.
  - sign_o = 0, bcd_o = 0, ovf_o = 0, valid_o = 0.
  - ready_o = 1 once reset is released.
- States: IDLE, CONVERT, DONE. ready_o = 1 only in IDLE. valid_o = 1 only in DONE. Both are decoded from registered state.
- IDLE:
  - On an edge with valid_i & ready_o, capture sign = diff_i[width].
  - Capture mag = sign ? (2^(width+1) - diff_i) : diff_i, computed in width+1 bits. So 9'h100 gives 256, not 0.
  - Clear the working BCD register and the ovf flag, set step = 0, go to CONVERT.
  - If valid_i is low, stay in IDLE.
- CONVERT: one double-dabble step per cycle, for width+1 cycles, MSB of mag first.
  - Step: add 3 to every working BCD digit >= 5, then shift {bcd, mag} left by one.
  - If the bit shifted out of the top digit is 1, set the sticky ovf flag.
  - step increments each cycle. On the edge completing step width, register sign_o, bcd_o and ovf_o from the working registers and go to DONE.
- Latency: valid_o rises width+1 edges after the acceptance edge (9 for width = 8). Throughput is one conversion per width+3 cycles with ready_i held high.
- DONE:
  - Outputs held stable.
  - On an edge with valid_o & ready_i, go to IDLE. Outputs keep their values but valid_o drops.
  - ready_i low: hold indefinitely. valid_i is ignored because ready_o = 0.
- No new input is accepted in the cycle the result is consumed. The earliest next acceptance is the following edge.
- sign_o/bcd_o/ovf_o change only on entry to DONE. During CONVERT they show the previous result, with valid_o = 0.
- Zero result: sign_o = 0. Negative zero cannot occur.
- Reset mid-CONVERT or mid-DONE: the conversion is abandoned, all outputs clear immediately, and there is no partial result.
- Every working BCD digit stays in the range 0..9 after each step. A value above 9 is a design error.

Test Plan:
1. width=8, digits=3; diff_i=9'h005, valid_i pulse, ready_i=1 -> after 9 edges valid_o=1, sign_o=0, bcd_o=12'h005, ovf_o=0; valid_o high exactly 1 cycle.
2. diff_i=9'h1FB (-5) -> sign_o=1, bcd_o=12'h005. Then diff_i=9'h101 (-255) -> sign_o=1, bcd_o=12'h255. Then diff_i=9'h0FF -> sign_o=0, bcd_o=12'h255.
3. Boundaries: diff_i=9'h100 -> sign_o=1, bcd_o=12'h256. diff_i=9'h000 -> sign_o=0, bcd_o=12'h000.
4. Backpressure: result 9'h07B (123) with ready_i=0 for 6 cycles.
   - valid_o stays 1 and bcd_o=12'h123 is held.
   - ready_o=0, and a concurrent valid_i with 9'h001 is ignored.
   - After ready_i=1, the next accepted op returns 12'h001.
5. Reset mid-conversion: assert rst_n_i low at step 4 of converting 9'h0C8.
   - All outputs are 0 asynchronously; ready_o=1 after release.
   - A following op with 9'h0C8 gives bcd_o=12'h200.
6. digits=2: diff_i=9'h064 (100) -> ovf_o=1, bcd_o=8'h00. diff_i=9'h063 (99) -> ovf_o=0, bcd_o=8'h99.

Source files
------------

// File: rtl/diff_bcd_decoder.sv
// Converts the subtractor's signed (width+1)-bit result into sign + magnitude packed BCD
// using one shift-add-3 step per cycle, with valid/ready handshakes on both sides.

module diff_bcd_decoder_chk #(
  parameter int digits = 3
) (
  input logic                  clk_i,
  input logic                  rst_n_i,
  input logic                  active_i,
  input logic [4*digits-1:0]   bcd_i
);

  function automatic logic digits_in_range(input logic [4*digits-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < digits; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  // Every working digit must remain a legal decimal digit between steps.
  always @(posedge clk_i) begin
    if (rst_n_i && active_i) begin
      assert (digits_in_range(bcd_i));
    end
  end

endmodule

module diff_bcd_decoder #(
  parameter int width  = 8,
  parameter int digits = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [width:0]        diff_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic                  sign_o,
  output logic [4*digits-1:0]   bcd_o,
  output logic                  ovf_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int BW = 4 * digits;
  localparam int SW = $clog2(width + 2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e          state_q;
  logic [SW-1:0]   step_q;
  logic [width:0]  mag_q;
  logic [BW-1:0]   wbcd_q;
  logic            ovf_q;
  logic            sign_q;
  logic            sign_out_q;
  logic [BW-1:0]   bcd_out_q;
  logic            ovf_out_q;

  logic [BW-1:0]   adj_s;
  logic [BW-1:0]   wbcd_d;
  logic [width:0]  mag_d;
  logic            ovf_d;
  logic [width:0]  mag_in_s;
  logic            last_step_s;

  function automatic logic [BW-1:0] add3_digits(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < digits; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One double-dabble step; a 1 leaving the top digit means the magnitude needs more digits.
  always_comb begin
    adj_s       = add3_digits(wbcd_q);
    wbcd_d      = {adj_s[BW-2:0], mag_q[width]};
    mag_d       = {mag_q[width-1:0], 1'b0};
    ovf_d       = ovf_q | adj_s[BW-1];
    last_step_s = (step_q == SW'(width));
    if (diff_i[width]) begin
      mag_in_s = ~diff_i + {{width{1'b0}}, 1'b1};
    end else begin
      mag_in_s = diff_i;
    end
  end

  // Control FSM together with the working and result registers it loads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      step_q     <= '0;
      mag_q      <= '0;
      wbcd_q     <= '0;
      ovf_q      <= 1'b0;
      sign_q     <= 1'b0;
      sign_out_q <= 1'b0;
      bcd_out_q  <= '0;
      ovf_out_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            sign_q  <= diff_i[width];
            mag_q   <= mag_in_s;
            wbcd_q  <= '0;
            ovf_q   <= 1'b0;
            step_q  <= '0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          wbcd_q <= wbcd_d;
          mag_q  <= mag_d;
          ovf_q  <= ovf_d;
          if (last_step_s) begin
            sign_out_q <= sign_q;
            bcd_out_q  <= wbcd_d;
            ovf_out_q  <= ovf_d;
            step_q     <= '0;
            state_q    <= DONE;
          end else begin
            step_q <= step_q + SW'(1);
          end
        end
        DONE: begin
          if (ready_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          step_q  <= '0;
        end
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign sign_o  = sign_out_q;
  assign bcd_o   = bcd_out_q;
  assign ovf_o   = ovf_out_q;

  diff_bcd_decoder_chk #(.digits(digits)) u_chk (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .active_i (state_q != IDLE),
    .bcd_i    (wbcd_q)
  );

endmodule

// File: tb/tb_diff_bcd_decoder.sv
// Randomised scoreboard bench: a 3-digit and a 2-digit decoder share one input stream and
// are compared against a decimal-arithmetic reference model.

module tb_diff_bcd_decoder;

  logic        clk;
  logic        rst_n;
  logic [8:0]  diff_i;
  logic        valid_i;
  logic        ready_i;

  logic        ready3, sign3, ovf3, valid3;
  logic [11:0] bcd3;
  logic        ready2, sign2, ovf2, valid2;
  logic [7:0]  bcd2;

  typedef struct packed {
    logic        sign;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
  } exp_t;

  exp_t q[$];
  exp_t last_exp;
  int   tests;
  int   fails;

  diff_bcd_decoder #(.width(8), .digits(3)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .diff_i(diff_i), .valid_i(valid_i), .ready_o(ready3),
    .sign_o(sign3), .bcd_o(bcd3), .ovf_o(ovf3), .valid_o(valid3), .ready_i(ready_i)
  );

  diff_bcd_decoder #(.width(8), .digits(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .diff_i(diff_i), .valid_i(valid_i), .ready_o(ready2),
    .sign_o(sign2), .bcd_o(bcd2), .ovf_o(ovf2), .valid_o(valid2), .ready_i(ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed value -> magnitude -> decimal digits by division.
  function automatic exp_t model(input logic [8:0] d);
    exp_t e;
    int   v;
    int   mag;
    int   p;
    v      = int'(d);
    e.sign = d[8];
    mag    = d[8] ? (512 - v) : v;
    e.bcd3 = 12'h000;
    e.bcd2 = 8'h00;
    p = 1;
    for (int i = 0; i < 3; i++) begin
      e.bcd3[4*i +: 4] = 4'((mag / p) % 10);
      if (i < 2) e.bcd2[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    e.ovf3 = (mag > 999);
    e.ovf2 = (mag > 99);
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid3 && ready_i) begin
      if (q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("sign3", 32'(sign3), 32'(e.sign));
        check("bcd3",  32'(bcd3),  32'(e.bcd3));
        check("ovf3",  32'(ovf3),  32'(e.ovf3));
        check("valid2", 32'(valid2), 32'd1);
        check("sign2", 32'(sign2), 32'(e.sign));
        check("bcd2",  32'(bcd2),  32'(e.bcd2));
        check("ovf2",  32'(ovf2),  32'(e.ovf2));
      end
    end
  end

  task automatic do_op(input logic [8:0] d);
    int n;
    @(negedge clk);
    valid_i = 1'b1;
    diff_i  = d;
    n = 0;
    while (!ready3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", 32'(ready3), 32'd1);
    q.push_back(model(d));
    last_exp = model(d);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    diff_i  = 9'($urandom_range(0, 511));
  endtask

  task automatic run_op(input logic [8:0] d, input int stall, input bit poke);
    int k;
    ready_i = (stall == 0);
    do_op(d);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!valid3 && k < 50);
    check("latency", 32'(k), 32'd9);
    if (stall > 0) begin
      if (poke) begin
        valid_i = 1'b1;
        diff_i  = 9'h001;
      end
      for (int s = 0; s < stall; s++) begin
        @(posedge clk);
        #1;
        check("hold_valid", 32'(valid3), 32'd1);
        check("hold_ready", 32'(ready3), 32'd0);
        check("hold_bcd",   32'(bcd3),   32'(last_exp.bcd3));
      end
      valid_i = 1'b0;
      ready_i = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid_one_cycle", 32'(valid3), 32'd0);
    check("ready_after",     32'(ready3), 32'd1);
  endtask

  initial begin
    logic [8:0] dirs [8];
    tests   = 0;
    fails   = 0;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    diff_i  = 9'h000;
    ready_i = 1'b1;
    dirs    = '{9'h005, 9'h1FB, 9'h101, 9'h0FF, 9'h100, 9'h000, 9'h064, 9'h063};

    #12;
    check("rst_valid", 32'(valid3), 32'd0);
    check("rst_bcd",   32'(bcd3),   32'd0);
    check("rst_sign",  32'(sign3),  32'd0);
    check("rst_ovf",   32'(ovf3),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(ready3), 32'd1);

    foreach (dirs[i]) run_op(dirs[i], 0, 1'b0);

    run_op(9'h07B, 6, 1'b1);
    run_op(9'h001, 0, 1'b0);

    // Abandon a conversion at step 4 and confirm nothing of it survives.
    ready_i = 1'b1;
    do_op(9'h0C8);
    repeat (4) @(posedge clk);
    #2;
    check("prev_result_held", 32'(bcd3), 32'h001);
    check("busy_not_valid",   32'(valid3), 32'd0);
    rst_n = 1'b0;
    #1;
    q.delete();
    check("arst_bcd",   32'(bcd3),   32'd0);
    check("arst_bcd2",  32'(bcd2),   32'd0);
    check("arst_sign",  32'(sign3),  32'd0);
    check("arst_ovf",   32'(ovf3),   32'd0);
    check("arst_valid", 32'(valid3), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst_ready", 32'(ready3), 32'd1);
    run_op(9'h0C8, 0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_op(9'($urandom_range(0, 511)), st, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
